// File: rtl/hdmi_timing_pkg.sv
// Shared raster constants for the HDMI output path: 1080p60 defaults,
// total derivation and the coordinate type used by the counters.
package hdmi_timing_pkg;

    localparam int COORD_W = 12;

    localparam int DEF_H_ACTIVE = 1920;
    localparam int DEF_H_FP     = 88;
    localparam int DEF_H_SYNC   = 44;
    localparam int DEF_H_BP     = 148;
    localparam int DEF_V_ACTIVE = 1080;
    localparam int DEF_V_FP     = 4;
    localparam int DEF_V_SYNC   = 5;
    localparam int DEF_V_BP     = 36;

    typedef logic [COORD_W-1:0] coord_t;

    function automatic int span_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/hdmi_sync_delay.sv
// Fixed-depth shift register with a loadable reset value, plus a single-bit
// tap at an intermediate depth for consumers that need an earlier copy.
module hdmi_sync_delay #(
    parameter int DEPTH   = 2,
    parameter int WIDTH   = 3,
    parameter int TAP     = 1,
    parameter int TAP_BIT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] rst_val,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             tap
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= rst_val;
            end
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dout = stage[DEPTH-1];

    // TAP counts cycles of delay: 0 is the undelayed input.
    generate
        if (TAP == 0) begin : g_tap_in
            assign tap = din[TAP_BIT];
        end else begin : g_tap_stage
            assign tap = stage[TAP-1][TAP_BIT];
        end
    endgenerate

endmodule

// File: rtl/hdmi_video_timing.sv
// Raster counters and sync decode for the HDMI path; re-aligns the colour
// returned by the downstream block with delayed hs/vs/de for the transmitter.
module hdmi_video_timing
    import hdmi_timing_pkg::*;
#(
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter logic SYNC_POL = 1'b1,
    parameter int   PIPE_DLY = 1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [11:0] px_x,
    output logic [11:0] px_y,
    output logic        data_en,
    output logic        frame_start,
    input  logic [7:0]  r,
    input  logic [7:0]  g,
    input  logic [7:0]  b,
    output logic [23:0] hdmi_d,
    output logic        hdmi_hs,
    output logic        hdmi_vs,
    output logic        hdmi_de
);

    localparam int H_TOTAL = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
    localparam coord_t H_ACT_C  = coord_t'(H_ACTIVE);
    localparam coord_t V_ACT_C  = coord_t'(V_ACTIVE);
    localparam coord_t HS_START = coord_t'(H_ACTIVE + H_FP);
    localparam coord_t HS_END   = coord_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam coord_t VS_START = coord_t'(V_ACTIVE + V_FP);
    localparam coord_t VS_END   = coord_t'(V_ACTIVE + V_FP + V_SYNC);

    localparam int DEPTH = PIPE_DLY + 1;

    coord_t x_q, y_q, x_nx, y_nx;
    logic   running;
    logic   de_q, fs_q;

    // The first free edge re-presents (0,0) with data_en/frame_start raised,
    // so counting only starts once the running flag is set.
    always_comb begin
        x_nx = '0;
        y_nx = '0;
        if (running) begin
            if (x_q == H_LAST) begin
                x_nx = '0;
                y_nx = (y_q == V_LAST) ? coord_t'(0) : y_q + coord_t'(1);
            end else begin
                x_nx = x_q + coord_t'(1);
                y_nx = y_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            running <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            de_q    <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            running <= 1'b1;
            x_q     <= x_nx;
            y_q     <= y_nx;
            de_q    <= (x_nx < H_ACT_C) && (y_nx < V_ACT_C);
            fs_q    <= (x_nx == '0) && (y_nx == '0);
        end
    end

    assign px_x        = x_q;
    assign px_y        = y_q;
    assign data_en     = de_q;
    assign frame_start = fs_q;

    logic hs_raw, vs_raw;
    logic [2:0] sync_in, sync_rst, sync_out;
    logic de_at_colour;

    assign hs_raw = (x_q >= HS_START) && (x_q < HS_END);
    assign vs_raw = (y_q >= VS_START) && (y_q < VS_END);

    // Polarity is applied before the delay line so the outputs come straight
    // from flops; bit 0 carries de.
    assign sync_in  = {hs_raw ? SYNC_POL : ~SYNC_POL,
                       vs_raw ? SYNC_POL : ~SYNC_POL,
                       de_q};
    assign sync_rst = {~SYNC_POL, ~SYNC_POL, 1'b0};

    hdmi_sync_delay #(
        .DEPTH   (DEPTH),
        .WIDTH   (3),
        .TAP     (PIPE_DLY),
        .TAP_BIT (0)
    ) u_sync_delay (
        .clk     (clk),
        .rst     (rst),
        .rst_val (sync_rst),
        .din     (sync_in),
        .dout    (sync_out),
        .tap     (de_at_colour)
    );

    assign hdmi_hs = sync_out[2];
    assign hdmi_vs = sync_out[1];
    assign hdmi_de = sync_out[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            hdmi_d <= '0;
        end else if (de_at_colour) begin
            hdmi_d <= {r, g, b};
        end else begin
            hdmi_d <= '0;
        end
    end

endmodule

// File: tb/tb_hdmi_video_timing.sv
// Bench for hdmi_video_timing: three instances (1080p defaults, small raster
// with both sync polarities) checked against a cycle-count raster model.
`timescale 1ns/1ps
module tb_hdmi_video_timing;

    typedef struct {
        int ha, hf, hs, hb;
        int va, vf, vs, vb;
        bit pol;
    } cfg_t;

    typedef struct {
        int          x, y;
        bit          de, fs, hs, vs, hde;
        logic [23:0] d;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [11:0] px_x [3];
    logic [11:0] px_y [3];
    logic        data_en [3], frame_start [3];
    logic        hs [3], vs [3], de [3];
    logic [23:0] d [3];
    logic [7:0]  r [3], g [3], b [3];

    cfg_t cfg [3];
    int   n;
    int   vectors = 0;
    int   miscompares = 0;

    hdmi_video_timing u_dut0 (
        .clk(clk), .rst(rst), .px_x(px_x[0]), .px_y(px_y[0]), .data_en(data_en[0]),
        .frame_start(frame_start[0]), .r(r[0]), .g(g[0]), .b(b[0]), .hdmi_d(d[0]),
        .hdmi_hs(hs[0]), .hdmi_vs(vs[0]), .hdmi_de(de[0])
    );

    hdmi_video_timing #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_POL(1'b1), .PIPE_DLY(1)
    ) u_dut1 (
        .clk(clk), .rst(rst), .px_x(px_x[1]), .px_y(px_y[1]), .data_en(data_en[1]),
        .frame_start(frame_start[1]), .r(r[1]), .g(g[1]), .b(b[1]), .hdmi_d(d[1]),
        .hdmi_hs(hs[1]), .hdmi_vs(vs[1]), .hdmi_de(de[1])
    );

    hdmi_video_timing #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_POL(1'b0), .PIPE_DLY(1)
    ) u_dut2 (
        .clk(clk), .rst(rst), .px_x(px_x[2]), .px_y(px_y[2]), .data_en(data_en[2]),
        .frame_start(frame_start[2]), .r(r[2]), .g(g[2]), .b(b[2]), .hdmi_d(d[2]),
        .hdmi_hs(hs[2]), .hdmi_vs(vs[2]), .hdmi_de(de[2])
    );

    // One-cycle colour block stand-in: colour encodes the pixel position.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            r[i] <= px_x[i][7:0];
            g[i] <= px_y[i][7:0];
            b[i] <= 8'hA5;
        end
    end

    // Raster from cycles since reset release (n<0: in/just out of reset);
    // transmitter side is the same raster two cycles earlier.
    function automatic exp_t model(input cfg_t c, input int cyc);
        exp_t e;
        int ht, vt, m, mx, my;
        bit hs_act, vs_act;
        ht = c.ha + c.hf + c.hs + c.hb;
        vt = c.va + c.vf + c.vs + c.vb;
        e.x = 0; e.y = 0; e.de = 1'b0; e.fs = 1'b0;
        e.hs = ~c.pol; e.vs = ~c.pol; e.hde = 1'b0; e.d = 24'h0;
        if (cyc >= 0) begin
            e.x  = cyc % ht;
            e.y  = (cyc / ht) % vt;
            e.de = (e.x < c.ha) && (e.y < c.va);
            e.fs = (e.x == 0) && (e.y == 0);
        end
        m = cyc - 2;
        if (m >= 0) begin
            mx = m % ht;
            my = (m / ht) % vt;
            hs_act = (mx >= c.ha + c.hf) && (mx < c.ha + c.hf + c.hs);
            vs_act = (my >= c.va + c.vf) && (my < c.va + c.vf + c.vs);
            e.hs  = hs_act ? c.pol : ~c.pol;
            e.vs  = vs_act ? c.pol : ~c.pol;
            e.hde = (mx < c.ha) && (my < c.va);
            e.d   = e.hde ? {8'(mx), 8'(my), 8'hA5} : 24'h0;
        end
        return e;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s n=%0d got=%0h exp=%0h", tag, n, got, exp);
        end
    endtask

    task automatic check_all();
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            e = model(cfg[i], n);
            check_val($sformatf("d%0d.px_x", i), 32'(px_x[i]), 32'(e.x));
            check_val($sformatf("d%0d.px_y", i), 32'(px_y[i]), 32'(e.y));
            check_val($sformatf("d%0d.data_en", i), 32'(data_en[i]), 32'(e.de));
            check_val($sformatf("d%0d.frame_start", i), 32'(frame_start[i]), 32'(e.fs));
            check_val($sformatf("d%0d.hdmi_hs", i), 32'(hs[i]), 32'(e.hs));
            check_val($sformatf("d%0d.hdmi_vs", i), 32'(vs[i]), 32'(e.vs));
            check_val($sformatf("d%0d.hdmi_de", i), 32'(de[i]), 32'(e.hde));
            check_val($sformatf("d%0d.hdmi_d", i), 32'(d[i]), 32'(e.d));
        end
    endtask

    // Called at a falling edge: check, set rst for the next rising edge.
    task automatic step(input logic rst_next);
        check_all();
        rst = rst_next;
        @(posedge clk);
        n = rst_next ? -1 : n + 1;
        @(negedge clk);
    endtask

    initial begin
        cfg[0] = '{1920, 88, 44, 148, 1080, 4, 5, 36, 1'b1};
        cfg[1] = '{8, 2, 2, 2, 4, 1, 1, 1, 1'b1};
        cfg[2] = '{8, 2, 2, 2, 4, 1, 1, 1, 1'b0};
        n = -1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        repeat (4) step(1'b1);

        // Free run: several small frames plus the first lines at 1080p.
        repeat (5000) step(1'b0);

        // One-cycle reset while the small raster sits at (5,2).
        repeat (2) step(1'b1);
        while (n != 33) step(1'b0);
        step(1'b1);
        repeat (150) step(1'b0);

        for (int ep = 0; ep < 8; ep++) begin
            repeat ($urandom_range(1, 3)) step(1'b1);
            repeat ($urandom_range(20, 300)) step(1'b0);
        end
        repeat (200) step(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
